// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared parity encodings, receiver FSM states and the 2-of-3 vote.
package uart_rx_fifo_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
  function automatic logic majority(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side handshake of the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0] RxData;
  logic RxValid;
  logic RxEnable;
  logic [$clog2(FIFO_DEPTH):0] RxCount;
  modport master (output RxData, RxValid, RxCount, input RxEnable);
  modport slave (input RxData, RxValid, RxCount, output RxEnable);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// uart_rx_fifo_sync_fifo: first-word-fall-through FIFO; when empty it presents the last word popped.
module uart_rx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   RxSamplerReset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = valid_o ? mem_q[rd_q] : last_q;
  assign count_o = cnt_q;
  always_ff @(posedge Clk or negedge RxSamplerReset)
    if (!RxSamplerReset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge Clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with 2-of-3 mid-bit voting, sticky error flags
// and a first-word-fall-through receive FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 1_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = PAR_NONE,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic           Clk,
  input  logic           RxSamplerReset,
  input  logic           RxWire,
  uart_rx_fifo_if.master rx,
  output logic           RxBusy,
  output logic           FramingError,
  output logic           ParityError,
  output logic           Overrun,
  input  logic           ClearErrors
);
  localparam int DIV = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int OW  = $clog2(OVERSAMPLE);
  state_t state_q;
  logic rx_meta_q, rx_sync_q, push_q, par_bad_q, fifo_full;
  logic [DW-1:0] div_q;
  logic [OW-1:0] os_q;
  logic [1:0] samp_q;
  logic [3:0] bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic tick, samp_en, mid, bit_end, bit_d, par_d;
  // os_q counts ticks since the bit began; the vote closes on the third sample
  assign tick    = div_q == DW'(DIV - 1);
  assign samp_en = tick & (os_q == OW'(OVERSAMPLE/2 - 2) | os_q == OW'(OVERSAMPLE/2 - 1));
  assign mid     = tick & (os_q == OW'(OVERSAMPLE/2));
  assign bit_end = tick & (os_q == OW'(OVERSAMPLE - 1));
  assign bit_d   = majority({samp_q, rx_sync_q});
  assign par_d   = ^data_q ^ (PARITY == PAR_ODD);
  always_ff @(posedge Clk or negedge RxSamplerReset)
    if (!RxSamplerReset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= S_IDLE;
      div_q        <= '0;
      os_q         <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      data_q       <= '0;
      par_bad_q    <= 1'b0;
      push_q       <= 1'b0;
      RxBusy       <= 1'b0;
      FramingError <= 1'b0;
      ParityError  <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      rx_meta_q <= RxWire;
      rx_sync_q <= rx_meta_q;
      push_q    <= 1'b0;
      div_q     <= (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;
      if (state_q == S_IDLE) os_q <= '0;
      else if (tick) os_q <= bit_end ? '0 : os_q + 1'b1;
      if (samp_en) samp_q <= {samp_q[0], rx_sync_q};
      // clears come first so an error raised in the same cycle survives
      if (ClearErrors) {FramingError, ParityError, Overrun} <= '0;
      if (push_q & fifo_full & ~rx.RxEnable) Overrun <= 1'b1;
      case (state_q)
        S_IDLE: if (!rx_sync_q) begin
          state_q   <= S_START;
          par_bad_q <= 1'b0;
          RxBusy    <= 1'b1;
        end
        S_START: if (mid & bit_d) begin
          state_q <= S_IDLE;
          RxBusy  <= 1'b0;
        end else if (bit_end) begin
          state_q <= S_DATA;
          bit_q   <= '0;
        end
        S_DATA: begin
          if (mid) data_q <= {bit_d, data_q[DATA_BITS-1:1]};
          if (bit_end) begin
            bit_q <= bit_q == 4'(DATA_BITS - 1) ? '0 : bit_q + 1'b1;
            if (bit_q == 4'(DATA_BITS - 1)) state_q <= PARITY != PAR_NONE ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (mid) begin
          par_bad_q <= bit_d != par_d;
          if (bit_d != par_d) ParityError <= 1'b1;
        end else if (bit_end) state_q <= S_STOP;
        S_STOP: if (mid) begin
          if (!bit_d) begin
            FramingError <= 1'b1;
            state_q      <= S_WAIT_IDLE;
          end else if (bit_q == 4'(STOP_BITS - 1)) begin
            push_q  <= ~par_bad_q;
            state_q <= S_IDLE;
            RxBusy  <= 1'b0;
          end
        end else if (bit_end) bit_q <= bit_q + 1'b1;
        S_WAIT_IDLE: if (rx_sync_q) begin
          state_q <= S_IDLE;
          RxBusy  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  uart_rx_fifo_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk           (Clk),
    .RxSamplerReset(RxSamplerReset),
    .push_i        (push_q),
    .data_i        (data_q),
    .pop_i         (rx.RxEnable),
    .data_o        (rx.RxData),
    .valid_o       (rx.RxValid),
    .full_o        (fifo_full),
    .count_o       (rx.RxCount)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into an 8N1 receiver and a 9-bit even-parity 2-stop receiver,
// checked every idle cycle against a queue model of the receive FIFO and error flags.
module tb_uart_rx_fifo;
  logic Clk = 0, rst_n = 0, line_a = 1, line_b = 1, clr_a = 0, clr_b = 0;
  logic busy_a, fe_a, pe_a, ov_a, busy_b, fe_b, pe_b, ov_b;
  logic chk_a = 0, chk_b = 0;
  logic [8:0] qa[$], qb[$];
  logic [8:0] last_a = 0, last_b = 0;
  logic [2:0] fl_a = 0, fl_b = 0;
  int checks = 0, errors = 0;
  always #5 Clk = ~Clk;
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ia();
  uart_rx_fifo_if #(.DATA_BITS(9), .FIFO_DEPTH(4)) ib();
  uart_rx_fifo dut_a (
    .Clk(Clk), .RxSamplerReset(rst_n), .RxWire(line_a), .rx(ia), .RxBusy(busy_a),
    .FramingError(fe_a), .ParityError(pe_a), .Overrun(ov_a), .ClearErrors(clr_a)
  );
  uart_rx_fifo #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) dut_b (
    .Clk(Clk), .RxSamplerReset(rst_n), .RxWire(line_b), .rx(ib), .RxBusy(busy_b),
    .FramingError(fe_b), .ParityError(pe_b), .Overrun(ov_b), .ClearErrors(clr_b)
  );
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge Clk) begin
    if (chk_a) begin
      cmp("a_valid", 32'(ia.RxValid), 32'(qa.size() != 0));
      cmp("a_count", 32'(ia.RxCount), 32'(qa.size()));
      cmp("a_data", 32'(ia.RxData), 32'(qa.size() != 0 ? qa[0] : last_a));
      cmp("a_busy", 32'(busy_a), 0);
      cmp("a_flags", 32'({fe_a, pe_a, ov_a}), 32'(fl_a));
    end
    if (chk_b) begin
      cmp("b_valid", 32'(ib.RxValid), 32'(qb.size() != 0));
      cmp("b_count", 32'(ib.RxCount), 32'(qb.size()));
      cmp("b_data", 32'(ib.RxData), 32'(qb.size() != 0 ? qb[0] : last_b));
      cmp("b_busy", 32'(busy_b), 0);
      cmp("b_flags", 32'({fe_b, pe_b, ov_b}), 32'(fl_b));
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic drive(input int d, input logic [15:0] bits, input int n, input int bt);
    for (int i = 0; i < n; i++) begin
      if (d == 0) line_a = bits[i]; else line_b = bits[i];
      step(bt);
    end
  endtask
  task automatic rx_a(input logic [7:0] d, input int bt);
    chk_a = 0;
    drive(0, {6'h3f, 1'b1, d, 1'b0}, 10, bt);
    step(4);
    if (qa.size() < 4) qa.push_back({1'b0, d}); else fl_a[0] = 1;
    chk_a = 1;
  endtask
  task automatic rx_b(input logic [8:0] d, input logic par);
    chk_b = 0;
    drive(1, {3'b111, 2'b11, par, d, 1'b0}, 13, 96);
    step(4);
    if (par != ^d) fl_b[1] = 1;
    else if (qb.size() < 4) qb.push_back(d);
    else fl_b[0] = 1;
    chk_b = 1;
  endtask
  task automatic pop(input int d);
    if (d == 0) ia.RxEnable = 1; else ib.RxEnable = 1;
    step(1);
    ia.RxEnable = 0;
    ib.RxEnable = 0;
    if (d == 0) begin
      if (qa.size() != 0) last_a = qa.pop_front();
    end else if (qb.size() != 0) last_b = qb.pop_front();
  endtask
  initial begin
    ia.RxEnable = 0;
    ib.RxEnable = 0;
    step(3);
    cmp("rst_valid", 32'(ia.RxValid), 0);
    cmp("rst_count", 32'(ia.RxCount), 0);
    cmp("rst_data", 32'(ia.RxData), 0);
    cmp("rst_busy_flags", 32'({busy_a, fe_a, pe_a, ov_a}), 0);
    rst_n = 1;
    step(5);
    chk_a = 1;
    chk_b = 1;
    // 9-bit even parity: 0x007 has odd weight so a 0 parity bit is wrong
    rx_b(9'h007, 1'b0);
    cmp("par_err", 32'(pe_b), 1);
    cmp("par_count", 32'(ib.RxCount), 0);
    clr_b = 1;
    step(1);
    clr_b = 0;
    fl_b = 0;
    cmp("par_clear", 32'(pe_b), 0);
    rx_b(9'h1FF, 1'b1);
    cmp("w9_data", 32'(ib.RxData), 32'h1FF);
    cmp("w9_count", 32'(ib.RxCount), 1);
    pop(1);
    // 8N1 basic pair
    rx_a(8'hA5, 96);
    rx_a(8'h3C, 96);
    cmp("t1_count", 32'(ia.RxCount), 2);
    cmp("t1_head", 32'(ia.RxData), 32'hA5);
    pop(0);
    cmp("t1_pop", 32'(ia.RxData), 32'h3C);
    pop(0);
    cmp("t1_hold", 32'({ia.RxValid, ia.RxData}), 32'h03C);
    pop(0);
    cmp("t1_empty_pop", 32'(ia.RxCount), 0);
    // glitch a quarter bit long
    chk_a = 0;
    line_a = 0;
    step(24);
    line_a = 1;
    step(100);
    chk_a = 1;
    cmp("glitch_busy", 32'(busy_a), 0);
    // stop bit held low
    chk_a = 0;
    drive(0, {6'h00, 1'b0, 8'h55, 1'b0}, 10, 96);
    step(150);
    cmp("frm_busy", 32'(busy_a), 1);
    cmp("frm_flag", 32'(fe_a), 1);
    cmp("frm_count", 32'(ia.RxCount), 0);
    line_a = 1;
    step(6);
    fl_a[2] = 1;
    chk_a = 1;
    clr_a = 1;
    step(1);
    clr_a = 0;
    fl_a = 0;
    cmp("frm_clear", 32'(fe_a), 0);
    // about 2% slow and fast senders
    rx_a(8'h96, 94);
    rx_a(8'h69, 98);
    cmp("baud_count", 32'(ia.RxCount), 2);
    pop(0);
    pop(0);
    // overflow: fifth frame is dropped
    rx_a(8'h11, 96);
    rx_a(8'h22, 96);
    rx_a(8'h33, 96);
    rx_a(8'h44, 96);
    rx_a(8'h55, 96);
    cmp("ovr_count", 32'(ia.RxCount), 4);
    cmp("ovr_flag", 32'(ov_a), 1);
    cmp("ovr_head", 32'(ia.RxData), 32'h11);
    pop(0);
    pop(0);
    pop(0);
    cmp("ovr_fourth", 32'(ia.RxData), 32'h44);
    // reset in the middle of data bit 3
    chk_a = 0;
    chk_b = 0;
    drive(0, {6'h3f, 1'b1, 8'hF0, 1'b0}, 4, 96);
    line_a = 0;
    step(48);
    rst_n = 0;
    line_a = 1;
    step(3);
    cmp("mid_rst_outs", 32'({ia.RxValid, ia.RxCount, busy_a, fe_a, pe_a, ov_a}), 0);
    cmp("mid_rst_data", 32'(ia.RxData), 0);
    rst_n = 1;
    qa.delete();
    qb.delete();
    last_a = 0;
    last_b = 0;
    fl_a = 0;
    fl_b = 0;
    step(200);
    chk_a = 1;
    chk_b = 1;
    rx_a(8'h81, 96);
    cmp("post_rst_data", 32'(ia.RxData), 32'h81);
    pop(0);
    step(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
